// File: rtl/cla_pkg.sv
// Shared carry-lookahead types and helpers used by the group cells and the pipelined top.
package cla_pkg;

    // Propagate/generate pair for a bit, a group, or a whole span of groups.
    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Combine a more-significant span (hi) with a less-significant span (lo).
    function automatic pg_t pg_merge(input pg_t hi, input pg_t lo);
        pg_t r;
        r.p = hi.p & lo.p;
        r.g = hi.g | (hi.p & lo.g);
        return r;
    endfunction

    // Number of pipeline stages needed to resolve n groups at per groups per stage.
    function automatic int calc_stages(input int n, input int per);
        return (n + per - 1) / per;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result bus of the pipelined adder: operand side and result side each
// follow valid/ready. A transfer happens on a rising edge where valid and ready
// are both high; valid never depends on ready, and ready may depend on valid.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;
    logic             P;
    logic             G;

    // Operand producer / result consumer side.
    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf, P, G
    );

    // Adder side.
    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, S, Cout, Ovf, P, G
    );
endinterface

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead cell: every internal carry is formed
// from the prefix propagate/generate of the lower bits and the group carry-in.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             cout,
    output logic             p,
    output logic             g
);
    logic [GROUP-1:0] w_bit_p;
    logic [GROUP-1:0] w_bit_g;
    logic [GROUP:0]   w_c;
    pg_t              w_acc;

    assign w_bit_p = a ^ b;
    assign w_bit_g = a & b;

    // Prefix-merge bit P/G from the LSB upward; each carry comes straight from the prefix and cin.
    always_comb begin
        w_acc    = '{p: 1'b1, g: 1'b0};
        w_c      = '0;
        w_c[0]   = cin;
        for (int i = 0; i < GROUP; i++) begin
            w_acc      = pg_merge('{p: w_bit_p[i], g: w_bit_g[i]}, w_acc);
            w_c[i + 1] = w_acc.g | (w_acc.p & cin);
        end
    end

    assign s    = w_bit_p ^ w_c[GROUP-1:0];
    assign cout = w_c[GROUP];
    assign p    = w_acc.p;
    assign g    = w_acc.g;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves GROUPS_PER_STAGE
// lookahead groups and registers the partial sum, the untouched operand bits, the
// carry into the next group and the running word-level P/G. Stages advance
// independently so bubbles collapse while the result end is stalled.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int GROUP            = 4,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    pipelined_cla_adder_if.slave bus
);
    localparam int NUM_GROUPS = WIDTH / GROUP;
    localparam int NUM_STAGES = calc_stages(NUM_GROUPS, GROUPS_PER_STAGE);
    localparam int LAST       = NUM_STAGES - 1;
    localparam int MSB        = WIDTH - 1;

    if (WIDTH % GROUP != 0) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
    end

    // Everything a stage hands to the next one.
    typedef struct packed {
        logic [WIDTH-1:0] a;      // operand A
        logic [WIDTH-1:0] bm;     // operand B after optional inversion for subtract
        logic [WIDTH-1:0] sum;    // sum bits resolved so far (zero above)
        logic             carry;  // carry into the next unresolved group
        logic             p;      // AND of propagate over resolved groups
        logic             g;      // lookahead generate over resolved groups
    } stage_t;

    stage_t           r_stage [NUM_STAGES];
    logic [LAST:0]    r_valid;

    stage_t           w_in    [NUM_STAGES];
    stage_t           w_next  [NUM_STAGES];
    logic [LAST:0]    w_vin;
    logic [LAST:0]    w_ready;

    logic [GROUP-1:0] w_gs [NUM_GROUPS];
    logic             w_gc [NUM_GROUPS];
    logic             w_gp [NUM_GROUPS];
    logic             w_gg [NUM_GROUPS];

    // Stage inputs: stage 0 sees the preprocessed operands, later stages the previous stage's registers.
    always_comb begin
        w_in[0].a     = bus.A;
        w_in[0].bm    = bus.Sub ? ~bus.B : bus.B;
        w_in[0].sum   = '0;
        w_in[0].carry = bus.Sub | bus.Cin;
        w_in[0].p     = 1'b1;
        w_in[0].g     = 1'b0;
        w_vin[0]      = bus.in_valid;
        for (int k = 1; k < NUM_STAGES; k++) begin
            w_in[k]  = r_stage[k-1];
            w_vin[k] = r_valid[k-1];
        end
    end

    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_grp
        localparam int ST = gi / GROUPS_PER_STAGE;
        logic             w_cin;
        logic             w_cout;
        logic [GROUP-1:0] w_s;
        logic             w_p;
        logic             w_g;

        if (gi % GROUPS_PER_STAGE == 0) begin : g_first
            assign w_cin = w_in[ST].carry;
        end else begin : g_chain
            assign w_cin = g_grp[gi-1].w_cout;
        end

        cla_group #(
            .GROUP (GROUP)
        ) u_grp (
            .a    (w_in[ST].a[gi*GROUP +: GROUP]),
            .b    (w_in[ST].bm[gi*GROUP +: GROUP]),
            .cin  (w_cin),
            .s    (w_s),
            .cout (w_cout),
            .p    (w_p),
            .g    (w_g)
        );

        assign w_gs[gi] = w_s;
        assign w_gc[gi] = w_cout;
        assign w_gp[gi] = w_p;
        assign w_gg[gi] = w_g;
    end

    // Fold each stage's groups into its outgoing partial sum, carry and running P/G.
    always_comb begin
        pg_t acc;
        acc = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_next[k] = w_in[k];
            for (int gi = 0; gi < NUM_GROUPS; gi++) begin
                if (gi / GROUPS_PER_STAGE == k) begin
                    w_next[k].sum[gi*GROUP +: GROUP] = w_gs[gi];
                    w_next[k].carry                  = w_gc[gi];
                    acc = pg_merge('{p: w_gp[gi], g: w_gg[gi]},
                                   '{p: w_next[k].p, g: w_next[k].g});
                    w_next[k].p = acc.p;
                    w_next[k].g = acc.g;
                end
            end
        end
    end

    // A stage may load when it or some stage between it and the output has room, or the consumer takes a result.
    always_comb begin
        logic full;
        full = 1'b1;
        for (int k = 0; k < NUM_STAGES; k++) begin
            full = 1'b1;
            for (int j = k; j < NUM_STAGES; j++) begin
                full = full & r_valid[j];
            end
            w_ready[k] = ~full | bus.out_ready;
        end
    end

    // Stage registers: valid follows upstream when the stage can move; data only changes on a real load.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_valid <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (w_ready[k]) begin
                    r_valid[k] <= w_vin[k];
                    if (w_vin[k]) begin
                        r_stage[k] <= w_next[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = w_ready[0];
    assign bus.out_valid = r_valid[LAST];
    assign bus.S         = r_stage[LAST].sum;
    assign bus.Cout      = r_stage[LAST].carry;
    assign bus.P         = r_stage[LAST].p;
    assign bus.G         = r_stage[LAST].g;
    // Carry into the MSB is recovered from the MSB's operand and sum bits.
    assign bus.Ovf       = r_stage[LAST].carry ^
                           (r_stage[LAST].a[MSB] ^ r_stage[LAST].bm[MSB] ^ r_stage[LAST].sum[MSB]);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for the pipelined adder: directed corner cases, a stalled burst, randomized
// traffic with random back-pressure, and a mid-flight reset, all scored against an
// arithmetic reference model.
module tb_pipelined_cla_adder;
    localparam int W = 16;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    // Expected results as {G, P, Ovf, Cout, S}.
    logic [W+3:0] exp_q[$];

    pipelined_cla_adder_if #(.WIDTH(W)) bus ();

    pipelined_cla_adder #(
        .WIDTH            (W),
        .GROUP            (4),
        .GROUPS_PER_STAGE (2)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Reference: plain modular arithmetic.
    function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] bm;
        logic         ci;
        logic [W:0]   full;
        logic [W:0]   nocarry;
        logic [W-1:0] low;
        logic         ovf;
        logic         p;
        bm      = sub ? ~b : b;
        ci      = sub ? 1'b1 : cin;
        full    = {1'b0, a} + {1'b0, bm} + {{W{1'b0}}, ci};
        nocarry = {1'b0, a} + {1'b0, bm};
        low     = {1'b0, a[W-2:0]} + {1'b0, bm[W-2:0]} + {{(W-1){1'b0}}, ci};
        ovf     = full[W] ^ low[W-1];
        p       = ((a ^ bm) == {W{1'b1}});
        return {nocarry[W], p, ovf, full[W], full[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
        bus.Sub      = sub;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboard: record accepted operands, compare each delivered result in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.A, bus.B, bus.Cin, bus.Sub));
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (exp_q.size() == 0)
                    check("unexpected_out", 32'(bus.out_valid), 32'd0);
                else
                    check("result", {12'd0, bus.G, bus.P, bus.Ovf, bus.Cout, bus.S},
                          {12'd0, exp_q.pop_front()});
            end
        end
    end

    // One op with free-flowing output; checks latency and fields against literal values.
    task automatic run_directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub, input logic [W-1:0] es,
                                input logic ec, input logic eo, input logic ep, input logic eg);
        bit seen;
        int cyc;
        seen = 1'b0;
        cyc  = 0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drive(1'b1, a, b, cin, sub);
        @(posedge clk); #1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                cyc  = i + 1;
                break;
            end
        end
        check({tag, "_valid"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'd2);
        check({tag, "_S"}, 32'(bus.S), 32'(es));
        check({tag, "_Cout"}, 32'(bus.Cout), 32'(ec));
        check({tag, "_Ovf"}, 32'(bus.Ovf), 32'(eo));
        check({tag, "_P"}, 32'(bus.P), 32'(ep));
        check({tag, "_G"}, 32'(bus.G), 32'(eg));
    endtask

    initial begin
        int  out0;
        int  acc_cnt;
        bit  fired;
        bit  saw;

        // Reset held for three cycles.
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_S", 32'(bus.S), 32'd0);
        check("rst_Cout", 32'(bus.Cout), 32'd0);
        check("rst_Ovf", 32'(bus.Ovf), 32'd0);
        check("rst_PG", 32'({bus.P, bus.G}), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed corner cases.
        run_directed("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        run_directed("add_wrap",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_directed("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_directed("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        run_directed("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);

        // Burst of 8 with the consumer stalled for 4 cycles starting at cycle 3.
        @(posedge clk); #1;
        out0    = n_out;
        acc_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            bus.out_ready = !(c >= 3 && c < 7);
            if (acc_cnt < 8)
                drive(1'b1, pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
            else
                drive(1'b0, '0, '0, 1'b0, 1'b0);
            @(negedge clk);
            fired = bus.in_valid && bus.in_ready;
            if (c == 5)
                check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            if (!bus.out_ready && bus.out_valid && exp_q.size() > 0)
                check("stall_S", 32'(bus.S), 32'(exp_q[0][W-1:0]));
            @(posedge clk); #1;
            if (fired) acc_cnt++;
            if (acc_cnt >= 8 && exp_q.size() == 0 && c >= 7) break;
        end
        check("burst_count", 32'(n_out - out0), 32'd8);
        check("burst_q_empty", 32'(exp_q.size()), 32'd0);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), pick_operand(), pick_operand(),
                  1'($urandom), 1'($urandom));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("rand_drain_empty", 32'(exp_q.size()), 32'd0);

        // Reset with two ops in flight: neither may ever appear.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) saw = 1'b1;
        end
        check("flush_no_result", 32'(saw), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
